spike_encoder: RTL

Downstream digitiser for the neuron model. Samples the neuron's real-valued membrane voltage every clock and detects threshold crossings, with hysteresis and a refractory period. Each spike is emitted as a one-cycle pulse, counted, and pushed as a timestamp event into a small FIFO with a valid/ready output handshake. It converts the analog-behavioural neuron output into discrete spike events for later digital stages.

---
 rtl/spike_encoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spike_encoder.sv
// spike_encoder: threshold-crossing digitiser with hysteresis,
// refractory hold-off and a show-ahead timestamp event FIFO.
module spike_encoder #(
  parameter real V_TH          = 0.5,
  parameter real V_HYST        = 0.1,
  parameter int  REFRAC_CYCLES = 16,
  parameter int  TS_WIDTH      = 16,
  parameter int  CNT_WIDTH     = 16,
  parameter int  FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  real                  V_in,
  input  logic                 en,
  output logic                 spike,
  output logic                 refractory,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [TS_WIDTH-1:0]  ev_ts,
  output logic [CNT_WIDTH-1:0] spike_count,
  output logic                 overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam real V_REARM = V_TH - V_HYST;
  localparam logic [7:0] REFR_LD =
    (REFRAC_CYCLES > 0) ? 8'(REFRAC_CYCLES - 1) : 8'd0;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ARMED      = 2'd0,
    REFRAC     = 2'd1,
    REARM_WAIT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [7:0]          refr_ctr;
  logic [TS_WIDTH-1:0] ts_ctr;
  logic [TS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         occ;
  logic                above;
  logic                below;
  logic                fire;
  logic                full;
  logic                empty;
  logic                pop;
  logic                push_ok;
  logic                drop;

  assign above = (V_in >= V_TH);
  assign below = (V_in < V_REARM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= REARM_WAIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (en) begin
      unique case (state)
        ARMED: begin
          if (above)
            state_nx = (REFRAC_CYCLES > 0) ? REFRAC : REARM_WAIT;
        end
        REFRAC: begin
          if (refr_ctr == 8'd0) state_nx = REARM_WAIT;
        end
        REARM_WAIT: begin
          if (below) state_nx = ARMED;
        end
        default: state_nx = REARM_WAIT;
      endcase
    end
  end

  always_comb begin
    fire       = en && (state == ARMED) && above;
    refractory = (state == REFRAC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refr_ctr <= 8'd0;
    end else if (en) begin
      if (fire)
        refr_ctr <= REFR_LD;
      else if (state == REFRAC && refr_ctr != 8'd0)
        refr_ctr <= refr_ctr - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_ctr      <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      spike <= fire;
      if (en) ts_ctr <= ts_ctr + TS_WIDTH'(1);
      if (fire && spike_count != '1)
        spike_count <= spike_count + CNT_WIDTH'(1);
    end
  end

  // A full FIFO still takes the push when the head leaves this cycle.
  assign empty   = (occ == '0);
  assign full    = (occ == DEPTH);
  assign pop     = !empty && ev_ready;
  assign push_ok = fire && (!full || pop);
  assign drop    = fire && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= ts_ctr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)
        occ <= occ + (AW+1)'(1);
      else if (pop && !push_ok)
        occ <= occ - (AW+1)'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign ev_valid = !empty;
  assign ev_ts    = empty ? '0 : mem[rd_ptr];

endmodule
